// File: rtl/pc_r32i_pkg.sv
// Shared definitions for the RV32I program counter: B-type funct3 branch codes
// and the default address width.
package pc_r32i_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage : pc_r32i_pkg

// File: rtl/pc_branch_cond.sv
// Branch-taken decision: picks the ALU compare flag named by the B-type funct3.
// Unused codes (010, 011) never take the branch.
module pc_branch_cond
  import pc_r32i_pkg::*;
(
  input  logic [2:0] PCBranchType,
  input  logic       EQ,
  input  logic       NE,
  input  logic       LT,
  input  logic       LTU,
  input  logic       GE,
  input  logic       GEU,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (PCBranchType)
      BEQ:     taken_o = EQ;
      BNE:     taken_o = NE;
      BLT:     taken_o = LT;
      BGE:     taken_o = GE;
      BLTU:    taken_o = LTU;
      BGEU:    taken_o = GEU;
      default: taken_o = 1'b0;
    endcase
  end

endmodule : pc_branch_cond

// File: rtl/pc_r32i.sv
// RV32I program counter: sequential, PC-relative and absolute (JALR) next-address
// selection with a single registered PC driving ProgAddr.
module pc_r32i
  import pc_r32i_pkg::*;
#(
  parameter int unsigned           dataW      = DataW,
  parameter logic [dataW-1:0]      ResetAddr  = '0,
  parameter int unsigned           InstrBytes = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EQ,
  input  logic             NE,
  input  logic             LT,
  input  logic             LTU,
  input  logic             GE,
  input  logic             GEU,
  input  logic             TestBranch,
  input  logic [2:0]       PCBranchType,
  input  logic [dataW-1:0] BranchAddr,
  input  logic             AlwaysBranch,
  input  logic             AbsoluteBranch,
  output logic [dataW-1:0] ProgAddr
);

  logic [dataW-1:0] pc_q;
  logic [dataW-1:0] pc_d;
  logic             cond_taken;

  pc_branch_cond u_branch_cond (
    .PCBranchType (PCBranchType),
    .EQ           (EQ),
    .NE           (NE),
    .LT           (LT),
    .LTU          (LTU),
    .GE           (GE),
    .GEU          (GEU),
    .taken_o      (cond_taken)
  );

  // Unconditional jumps outrank conditional branches; sums wrap modulo 2^dataW.
  always_comb begin
    pc_d = pc_q + dataW'(InstrBytes);
    if (AlwaysBranch) begin
      if (AbsoluteBranch) begin
        pc_d = {BranchAddr[dataW-1:1], 1'b0};
      end else begin
        pc_d = pc_q + BranchAddr;
      end
    end else if (TestBranch && cond_taken) begin
      pc_d = pc_q + BranchAddr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= ResetAddr;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign ProgAddr = pc_q;

endmodule : pc_r32i

// File: tb/tb_pc_r32i.sv
// Randomised self-checking bench for pc_r32i: directed walk through the branch
// modes followed by random traffic compared against a next-PC reference model.
module tb_pc_r32i;
  import pc_r32i_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        EQ, NE, LT, LTU, GE, GEU;
  logic        TestBranch;
  logic [2:0]  PCBranchType;
  logic [31:0] BranchAddr;
  logic        AlwaysBranch;
  logic        AbsoluteBranch;
  logic [31:0] ProgAddr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_pc;

  pc_r32i dut (
    .clock          (clock),
    .reset          (reset),
    .EQ             (EQ),
    .NE             (NE),
    .LT             (LT),
    .LTU            (LTU),
    .GE             (GE),
    .GEU            (GEU),
    .TestBranch     (TestBranch),
    .PCBranchType   (PCBranchType),
    .BranchAddr     (BranchAddr),
    .AlwaysBranch   (AlwaysBranch),
    .AbsoluteBranch (AbsoluteBranch),
    .ProgAddr       (ProgAddr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: ProgAddr=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: ProgAddr=%08h", tag, got);
    end
  endtask

  // flags packed as {GEU, GE, LTU, LT, NE, EQ}
  task automatic drive(input logic ab, input logic abs, input logic tst,
                       input logic [2:0] ty, input logic [31:0] addr, input logic [5:0] fl);
    AlwaysBranch   = ab;
    AbsoluteBranch = abs;
    TestBranch     = tst;
    PCBranchType   = ty;
    BranchAddr     = addr;
    {GEU, GE, LTU, LT, NE, EQ} = fl;
  endtask

  // Reference: RISC-V next-PC rule computed with 64-bit arithmetic then truncated.
  function automatic logic [31:0] model_next(input logic [31:0] pc);
    longint unsigned sum_rel;
    bit cond;
    sum_rel = (longint'(pc) + longint'(BranchAddr)) % 64'h1_0000_0000;
    case (PCBranchType)
      3'd0: cond = EQ;
      3'd1: cond = NE;
      3'd4: cond = LT;
      3'd5: cond = GE;
      3'd6: cond = LTU;
      3'd7: cond = GEU;
      default: cond = 1'b0;
    endcase
    if (AlwaysBranch && AbsoluteBranch) return BranchAddr & 32'hFFFF_FFFE;
    if (AlwaysBranch || (TestBranch && cond)) return sum_rel[31:0];
    return (pc + 32'd4);
  endfunction

  task automatic step(input string tag, input logic [31:0] exp);
    @(posedge clock);
    #1;
    model_pc = model_next(model_pc);
    check(tag, ProgAddr, exp);
  endtask

  logic [2:0] codes [5] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  int         fidx  [5] = '{1, 2, 4, 3, 5};

  initial begin
    logic [31:0] cur;
    logic [5:0]  fl;
    drive(0, 0, 0, 3'd0, 32'd0, 6'd0);
    model_pc = 32'd0;
    #3;
    check("reset_state", ProgAddr, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    step("seq0", 32'd4);
    step("seq1", 32'd8);
    step("seq2", 32'd12);

    drive(1, 0, 0, 3'd0, 32'd64, 6'd0);
    step("jal_rel0", 32'd76);
    step("jal_rel1", 32'd140);

    drive(1, 1, 0, 3'd0, 32'd64, 6'd0);
    step("jalr0", 32'd64);
    step("jalr1", 32'd64);
    BranchAddr = 32'd65;
    step("jalr_bit0", 32'd64);

    drive(0, 0, 1, BEQ, 32'd64, 6'd0);
    step("beq_nt", 32'd68);
    EQ = 1'b1;
    step("beq_t", 32'd132);

    drive(1, 0, 0, 3'd0, -32'sd8, 6'd0);
    step("rel_neg", 32'd124);

    for (int i = 0; i < 5; i++) begin
      cur = model_pc;
      fl = 6'd0;
      fl[fidx[i]] = 1'b1;
      drive(0, 0, 1, codes[i], 32'd64, fl);
      step($sformatf("br%0d_taken", codes[i]), cur + 32'd64);
      fl[fidx[i]] = 1'b0;
      drive(0, 0, 1, codes[i], 32'd64, fl);
      step($sformatf("br%0d_not", codes[i]), cur + 32'd68);
    end

    for (int c = 2; c < 4; c++) begin
      cur = model_pc;
      drive(0, 0, 1, 3'(c), 32'd64, 6'h3F);
      step($sformatf("code%0d_ignored", c), cur + 32'd4);
    end

    cur = model_pc;
    drive(0, 1, 0, 3'd0, 32'd256, 6'h3F);
    step("abs_ignored", cur + 32'd4);
    cur = model_pc;
    drive(1, 0, 1, BEQ, 32'd32, 6'd0);
    step("test_ignored", cur + 32'd32);

    drive(1, 1, 0, 3'd0, 32'hFFFF_FFFD, 6'd0);
    step("jalr_top", 32'hFFFF_FFFC);
    drive(0, 0, 0, 3'd0, 32'd0, 6'd0);
    step("wrap", 32'd0);

    #2;
    reset = 1'b0;
    #1;
    check("async_reset", ProgAddr, 32'd0);
    drive(1, 0, 0, 3'd0, 32'd100, 6'd0);
    @(posedge clock);
    #1;
    check("reset_hold", ProgAddr, 32'd0);
    model_pc = 32'd0;
    reset = 1'b1;
    step("after_reset", 32'd100);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] exp_pc;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(12'($urandom))),
            6'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        check($sformatf("rnd%0d_reset", i), ProgAddr, 32'd0);
        model_pc = 32'd0;
        @(negedge clock);
        reset = 1'b1;
      end
      exp_pc = model_next(model_pc);
      @(posedge clock);
      #1;
      model_pc = exp_pc;
      check($sformatf("rnd%0d", i), ProgAddr, exp_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_r32i
